block_config_loader: RTL and testbench

//   Serial-to-parallel configuration loader that sits directly upstream of block_config_latches.

---
 rtl/block_config_loader.sv | 136 +++++++++++++
 tb/tb_block_config_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/block_config_loader.sv
// Bit-serial to parallel configuration loader feeding block_config_latches.
// Assembles one MEM_SIZE-bit frame, then holds comb_set for SET_CYCLES cycles.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset; waiting for cfg_start, serial input ignored
// SHIFT | accepting beats into sr; cfg_start restarts the frame
// SET   | config_in stable, comb_set high for SET_CYCLES cycles
// DONE  | frame committed, done high; cfg_start begins a reload
module block_config_loader #(
  parameter int ADDR_BITS  = 4,
  parameter int MEM_SIZE   = 2**ADDR_BITS,
  parameter int SET_CYCLES = 2,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_bit,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [MEM_SIZE-1:0] config_in,
  output logic                comb_set,
  output logic                done
);

  localparam int CW = ADDR_BITS + 1;
  localparam int SW = (SET_CYCLES < 2) ? 1 : $clog2(SET_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_SIZE - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SET_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SET   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [MEM_SIZE-1:0] sr, sr_n, sr_shift, config_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [SW-1:0]       scnt, scnt_n;
  logic                ready_n, set_n, done_n;
  logic                beat;

  // cfg_ready is registered and high only in SHIFT, so a beat implies SHIFT.
  assign beat = cfg_valid & cfg_ready;

  always_comb begin
    if (LSB_FIRST) sr_shift = {cfg_bit, sr[MEM_SIZE-1:1]};
    else           sr_shift = {sr[MEM_SIZE-2:0], cfg_bit};
  end

  always_comb begin
    state_n  = state;
    sr_n     = sr;
    cnt_n    = cnt;
    scnt_n   = scnt;
    config_n = config_in;
    ready_n  = cfg_ready;
    set_n    = comb_set;
    done_n   = done;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_n = SHIFT;
          cnt_n   = '0;
          ready_n = 1'b1;
        end
      end
      SHIFT: begin
        if (cfg_start) begin
          cnt_n = '0;
        end else if (beat) begin
          sr_n = sr_shift;
          // The final beat commits the frame and leaves cnt at MEM_SIZE-1.
          if (cnt == CNT_LAST) begin
            state_n  = SET;
            config_n = sr_shift;
            set_n    = 1'b1;
            scnt_n   = SW'(1);
            ready_n  = 1'b0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      SET: begin
        if (scnt == SET_LAST) begin
          state_n = DONE;
          set_n   = 1'b0;
          done_n  = 1'b1;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
      DONE: begin
        if (cfg_start) begin
          state_n = SHIFT;
          done_n  = 1'b0;
          cnt_n   = '0;
          ready_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        ready_n = 1'b0;
        set_n   = 1'b0;
        done_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      scnt      <= '0;
      config_in <= '0;
      cfg_ready <= 1'b0;
      comb_set  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      scnt      <= scnt_n;
      config_in <= config_n;
      cfg_ready <= ready_n;
      comb_set  <= set_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_block_config_loader.sv
// Bench for block_config_loader: three parameterisations checked every cycle
// against a frame-level model built from accepted-bit queues.
module tb_block_config_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  st = '0, vl = '0, bt = '0;
  logic [2:0]  rdy, cs, dn;
  logic [15:0] cfg0, cfg1;
  logic [63:0] cfg2;

  always #5 clk = ~clk;

  block_config_loader #(.ADDR_BITS(4), .SET_CYCLES(2), .LSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .cfg_start(st[0]), .cfg_bit(bt[0]), .cfg_valid(vl[0]),
    .cfg_ready(rdy[0]), .config_in(cfg0), .comb_set(cs[0]), .done(dn[0]));
  block_config_loader #(.ADDR_BITS(4), .SET_CYCLES(3), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .cfg_start(st[1]), .cfg_bit(bt[1]), .cfg_valid(vl[1]),
    .cfg_ready(rdy[1]), .config_in(cfg1), .comb_set(cs[1]), .done(dn[1]));
  block_config_loader #(.ADDR_BITS(6), .SET_CYCLES(2), .LSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .cfg_start(st[2]), .cfg_bit(bt[2]), .cfg_valid(vl[2]),
    .cfg_ready(rdy[2]), .config_in(cfg2), .comb_set(cs[2]), .done(dn[2]));

  int passed = 0, total = 0;
  int sel = 0;
  int rises, highs;
  logic prev_cs;

  // Reference model: collecting flag, accepted bits, remaining pulse cycles.
  bit          m_act;
  int          m_pulse;
  bit          m_done;
  logic [63:0] m_frame;
  bit          m_q[$];

  function automatic int ms(int s);
    return (s == 2) ? 64 : 16;
  endfunction
  function automatic int sc(int s);
    return (s == 1) ? 3 : 2;
  endfunction
  function automatic bit lf(int s);
    return (s == 1);
  endfunction

  function automatic logic [63:0] get_cfg();
    case (sel)
      0:       return {48'b0, cfg0};
      1:       return {48'b0, cfg1};
      default: return cfg2;
    endcase
  endfunction

  function automatic logic [63:0] assemble();
    logic [63:0] f;
    int m;
    f = '0;
    m = ms(sel);
    for (int i = 0; i < m; i++)
      if (m_q[i]) f[lf(sel) ? i : m - 1 - i] = 1'b1;
    return f;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s (inst %0d): observed %0h required %0h", tag, sel, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      m_act = 0; m_pulse = 0; m_done = 0; m_frame = '0; m_q.delete();
    end else if (m_pulse > 0) begin
      m_pulse--;
      if (m_pulse == 0) m_done = 1;
    end else if (st[sel]) begin
      m_act = 1; m_done = 0; m_q.delete();
    end else if (m_act && vl[sel]) begin
      m_q.push_back(bt[sel]);
      if (m_q.size() == ms(sel)) begin
        m_frame = assemble();
        m_act   = 0;
        m_pulse = sc(sel);
      end
    end
    #1;
    if (cs[sel] && !prev_cs) rises++;
    if (cs[sel]) highs++;
    prev_cs = cs[sel];
    check("cfg_ready", 64'(rdy[sel]), 64'(m_act));
    check("comb_set", 64'(cs[sel]), 64'(m_pulse > 0));
    check("done", 64'(dn[sel]), 64'(m_done));
    check("config_in", get_cfg(), m_frame);
  endtask

  task automatic step(bit s, bit v, bit b);
    st[sel] = s; vl[sel] = v; bt[sel] = b;
    cyc();
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic do_reset();
    st = '0; vl = '0; bt = '0;
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    prev_cs = 1'b0;
  endtask

  task automatic send(logic [63:0] w, int n, bit toggle);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = w[n - 1 - i];
      step(0, 1, b);
      if (toggle && i != n - 1) step(0, 0, 1'($urandom));
    end
  endtask

  task automatic random_run(int s, int cycles);
    bit r, a;
    sel = s;
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      r = ($urandom_range(0, 199) == 0);
      a = m_act ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 5) == 0);
      rst = r;
      step(a, ($urandom_range(0, 3) != 0), 1'($urandom));
      rst = 1'b0;
    end
  endtask

  initial begin : main
    logic [63:0] w;
    prev_cs = 1'b0;
    rises = 0; highs = 0;

    // 1: back-to-back 0xA5C3, MSB first
    sel = 0;
    do_reset();
    rises = 0;
    step(1, 0, 0);
    send(64'hA5C3, 16, 0);
    check("t1_set_after_last_beat", 64'(cs[0]), 64'd1);
    idle(4);
    check("t1_frame", {48'b0, cfg0}, 64'hA5C3);
    check("t1_done", 64'(dn[0]), 64'd1);
    check("t1_pulses", 64'(rises), 64'd1);

    // 2: same frame with valid toggling
    rises = 0;
    step(1, 0, 0);
    send(64'hA5C3, 16, 1);
    idle(4);
    check("t2_frame", {48'b0, cfg0}, 64'hA5C3);
    check("t2_pulses", 64'(rises), 64'd1);

    // 3: restart mid-frame
    rises = 0;
    step(1, 0, 0);
    repeat (5) step(0, 1, 0);
    step(1, 0, 0);
    repeat (16) step(0, 1, 1);
    idle(4);
    check("t3_frame", {48'b0, cfg0}, 64'hFFFF);
    check("t3_pulses", 64'(rises), 64'd1);

    // 4: reset during first SET cycle
    step(1, 0, 0);
    send(64'h1234, 16, 0);
    rst = 1'b1;
    step(0, 1, 1);
    rst = 1'b0;
    check("t4_comb_set", 64'(cs[0]), 64'd0);
    check("t4_config_in", {48'b0, cfg0}, 64'd0);
    check("t4_done", 64'(dn[0]), 64'd0);
    check("t4_ready", 64'(rdy[0]), 64'd0);
    repeat (5) step(0, 1, 1);
    check("t4_ignored_cfg", {48'b0, cfg0}, 64'd0);
    check("t4_ignored_ready", 64'(rdy[0]), 64'd0);

    // 5: LSB first, three-cycle pulse
    sel = 1;
    do_reset();
    step(1, 0, 0);
    highs = 0;
    step(0, 1, 1);
    repeat (15) step(0, 1, 0);
    idle(6);
    check("t5_frame", {48'b0, cfg1}, 64'h0001);
    check("t5_high_cycles", 64'(highs), 64'd3);

    // 6: 64-bit frame with inputs that must be ignored
    sel = 2;
    do_reset();
    repeat (3) step(0, 1, 1);
    step(1, 0, 0);
    w = {32'($urandom), 32'($urandom)};
    send(w, 64, 0);
    repeat (2) step(1, 1, 1);
    repeat (3) step(0, 1, 1);
    check("t6_frame", cfg2, w);
    check("t6_done", 64'(dn[2]), 64'd1);
    check("t6_cnt_stop", 64'(u2.cnt), 64'd63);

    for (int s = 0; s < 3; s++) random_run(s, 1500);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
